uart_tx_fifo: RTL and testbench

Parametrised successor to the fixed-divider UART transmitter wrapper. It has a runtime baud divider, a configurable character width, and an internal transmit FIFO, so software can queue several characters without polling busy. Parity and stop-bit options are runtime inputs, sampled per frame. It sits between a register/bus front end and the serial TX pin.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_tx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmitter/receiver types, constants and parity helper
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP1,
      TX_STOP2
   } tx_state_e;

   localparam int UART_DEFAULT_DIVIDER = 217;
   localparam int UART_MIN_DIVIDER     = 2;
   localparam int UART_MAX_DATA_WIDTH  = 9;

   // Narrower characters are zero-extended, which leaves the XOR unchanged.
   function automatic logic uart_parity(input logic [UART_MAX_DATA_WIDTH-1:0] data,
                                        input logic                           even);
      return even ? (^data) : ~(^data);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with separate occupancy count
module uart_sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   // A simultaneous pop frees a slot, so a push into a full FIFO is still taken.
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clock_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop) begin
            count_q <= count_q + CW'(1);
         end else if (do_pop && !do_push) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - queued UART transmitter with runtime divider, parity and stop bits
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 16,
   parameter int DIVIDER_WIDTH = 16
) (
   input  logic                          clock_i,
   input  logic                          reset_i,
   input  logic                          write_i,
   input  logic [DATA_WIDTH-1:0]         data_i,
   input  logic                          two_stop_bits_i,
   input  logic                          parity_bit_i,
   input  logic                          parity_even_i,
   input  logic [DIVIDER_WIDTH-1:0]      clock_divider_i,
   output logic                          full_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic                          overflow_o,
   output logic                          busy_o,
   output logic                          serial_o
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [DIVIDER_WIDTH-1:0] MIN_DIV = DIVIDER_WIDTH'(UART_MIN_DIVIDER);

   tx_state_e                state_q, state_d;
   logic [DIVIDER_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, div_clamped;
   logic [BW-1:0]            bit_q, bit_d;
   logic [DATA_WIDTH-1:0]    shift_q, shift_d, fifo_data;
   logic                     par_en_q, par_en_d, par_val_q, par_val_d;
   logic                     two_stop_q, two_stop_d;
   logic                     serial_q, serial_d, overflow_q;
   logic                     pop, fifo_full, fifo_empty;
   logic                     bit_done, start_frame, end_frame;

   assign div_clamped = (clock_divider_i < MIN_DIV) ? MIN_DIV : clock_divider_i;
   assign bit_done    = (cnt_q == '0);

   uart_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .push_i  (write_i),
      .data_i  (data_i),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .count_o (fifo_count_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      div_d       = div_q;
      par_en_d    = par_en_q;
      par_val_d   = par_val_q;
      two_stop_d  = two_stop_q;
      serial_d    = 1'b1;
      start_frame = 1'b0;
      end_frame   = 1'b0;

      case (state_q)
         TX_IDLE:   start_frame = !fifo_empty;
         TX_START: begin
            serial_d = 1'b0;
            if (bit_done) begin
               state_d = TX_DATA;
               bit_d   = '0;
            end
         end
         TX_DATA: begin
            serial_d = shift_q[0];
            if (bit_done) begin
               shift_d = shift_q >> 1;
               if (bit_q == BW'(DATA_WIDTH - 1)) begin
                  state_d = par_en_q ? TX_PARITY : TX_STOP1;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         TX_PARITY: begin
            serial_d = par_val_q;
            if (bit_done) state_d = TX_STOP1;
         end
         TX_STOP1: begin
            if (bit_done) begin
               if (two_stop_q) state_d = TX_STOP2;
               else            end_frame = 1'b1;
            end
         end
         TX_STOP2:  end_frame = bit_done;
         default:   state_d = TX_IDLE;
      endcase

      if (state_q != TX_IDLE) begin
         cnt_d = bit_done ? (div_q - DIVIDER_WIDTH'(1)) : (cnt_q - DIVIDER_WIDTH'(1));
      end

      // Chaining straight from the last stop bit into START avoids an idle gap.
      if (end_frame) begin
         state_d     = TX_IDLE;
         start_frame = !fifo_empty;
      end

      if (start_frame) begin
         state_d    = TX_START;
         cnt_d      = div_clamped - DIVIDER_WIDTH'(1);
         div_d      = div_clamped;
         shift_d    = fifo_data;
         par_en_d   = parity_bit_i;
         two_stop_d = two_stop_bits_i;
         par_val_d  = uart_parity(UART_MAX_DATA_WIDTH'(fifo_data), parity_even_i);
      end
   end

   assign pop = start_frame;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= TX_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         div_q      <= MIN_DIV;
         par_en_q   <= 1'b0;
         par_val_q  <= 1'b0;
         two_stop_q <= 1'b0;
         serial_q   <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         div_q      <= div_d;
         par_en_q   <= par_en_d;
         par_val_q  <= par_val_d;
         two_stop_q <= two_stop_d;
         serial_q   <= serial_d;
         overflow_q <= write_i && fifo_full && !pop;
      end
   end

   assign serial_o   = serial_q;
   assign overflow_o = overflow_q;
   assign full_o     = fifo_full;
   assign busy_o     = (state_q != TX_IDLE) || (fifo_count_o != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo against a frame-level line model
module tb_uart_tx_fifo;

   localparam int DW   = 8;
   localparam int FD   = 16;
   localparam int DIVW = 16;
   localparam int LOGN = 8192;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            write = 1'b0;
   logic [DW-1:0]   data = '0;
   logic            two = 1'b0, par = 1'b0, even = 1'b0;
   logic [DIVW-1:0] div = 16'd4;
   logic            full, ovf, busy, ser;
   logic [4:0]      cnt;

   int errors = 0;
   int checks = 0;
   int ncnt   = 0;

   logic       ser_log  [LOGN];
   logic       busy_log [LOGN];
   logic       full_log [LOGN];
   logic       ovf_log  [LOGN];
   logic [4:0] cnt_log  [LOGN];
   logic       exp_q[$];

   uart_tx_fifo #(
      .DATA_WIDTH    (DW),
      .FIFO_DEPTH    (FD),
      .DIVIDER_WIDTH (DIVW)
   ) dut (
      .clock_i         (clk),
      .reset_i         (rst),
      .write_i         (write),
      .data_i          (data),
      .two_stop_bits_i (two),
      .parity_bit_i    (par),
      .parity_even_i   (even),
      .clock_divider_i (div),
      .full_o          (full),
      .fifo_count_o    (cnt),
      .overflow_o      (ovf),
      .busy_o          (busy),
      .serial_o        (ser)
   );

   always #5 clk = ~clk;

   // Sample index k of a test is the negedge following the k-th posedge after its first write.
   always @(negedge clk) begin
      if (ncnt < LOGN) begin
         ser_log[ncnt]  = ser;
         busy_log[ncnt] = busy;
         full_log[ncnt] = full;
         ovf_log[ncnt]  = ovf;
         cnt_log[ncnt]  = cnt;
      end
      ncnt = ncnt + 1;
   end

   task automatic add_idle(input int n);
      repeat (n) exp_q.push_back(1'b1);
   endtask

   task automatic add_frame(input logic [DW-1:0] d, input int dv, input bit p, input bit ev, input bit ts);
      int   eff;
      logic bits[$];
      eff = (dv < 2) ? 2 : dv;
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(d[i]);
      if (p) bits.push_back(ev ? ($countones(d) % 2 == 1) : ($countones(d) % 2 == 0));
      bits.push_back(1'b1);
      if (ts) bits.push_back(1'b1);
      foreach (bits[i]) repeat (eff) exp_q.push_back(bits[i]);
   endtask

   function automatic int first_mismatch(input int base);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i >= LOGN) return i;
         if (ser_log[base + i] !== exp_q[i]) return i;
      end
      return -1;
   endfunction

   task automatic push(input logic [DW-1:0] d);
      write = 1'b1;
      data  = d;
      @(posedge clk); #1;
      write = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #6;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (ser !== 1'b1)  begin errors++; $display("FAIL reset_serial got %b want 1", ser); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
      checks++; if (cnt !== 5'd0)  begin errors++; $display("FAIL reset_count got %0d want 0", cnt); end
      checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_overflow got %b want 0", ovf); end
      @(negedge clk);
      checks++; if (ser !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_idle_hold got serial=%b busy=%b want 1/0", ser, busy);
      end
   endtask

   task automatic test_basic();
      int base, mm;
      @(posedge clk); #1;
      div = 16'd4; par = 1'b0; two = 1'b0;
      exp_q.delete();
      add_idle(2); add_frame(8'h55, 4, 0, 0, 0); add_idle(4);
      base = ncnt + 1;
      push(8'h55);
      wait_cycles(50);
      checks++; if (ser_log[base+1] !== 1'b1) begin errors++; $display("FAIL basic_pre_start got %b want 1", ser_log[base+1]); end
      checks++; if (ser_log[base+2] !== 1'b0) begin errors++; $display("FAIL basic_latency got %b want 0", ser_log[base+2]); end
      mm = first_mismatch(base);
      checks++; if (mm != -1) begin errors++; $display("FAIL basic_wave sample %0d got %b want %b", mm, ser_log[base+mm], exp_q[mm]); end
      checks++; if (cnt_log[base] !== 5'd1) begin errors++; $display("FAIL basic_count_visible got %0d want 1", cnt_log[base]); end
      checks++; if (busy_log[base] !== 1'b1 || busy_log[base+38] !== 1'b1) begin
         errors++; $display("FAIL basic_busy_high got %b/%b want 1/1", busy_log[base], busy_log[base+38]);
      end
      checks++; if (busy_log[base+42] !== 1'b0) begin errors++; $display("FAIL basic_busy_drop got %b want 0", busy_log[base+42]); end
   endtask

   task automatic test_parity();
      int  base, mm;
      bit  ev;
      for (int k = 0; k < 2; k++) begin
         ev = (k == 0);
         @(posedge clk); #1;
         div = 16'd4; par = 1'b1; two = 1'b1; even = ev;
         exp_q.delete();
         add_idle(2); add_frame(8'h07, 4, 1, ev, 1); add_idle(4);
         base = ncnt + 1;
         push(8'h07);
         wait_cycles(2 + 48 + 6);
         mm = first_mismatch(base);
         checks++; if (mm != -1) begin errors++; $display("FAIL parity_wave even=%0d sample %0d got %b want %b", ev, mm, ser_log[base+mm], exp_q[mm]); end
         checks++; if (ser_log[base+2+36] !== ev) begin errors++; $display("FAIL parity_bit even=%0d got %b want %b", ev, ser_log[base+38], ev); end
         checks++; if (busy_log[base+2+48] !== 1'b0) begin errors++; $display("FAIL parity_frame_len even=%0d busy got %b want 0", ev, busy_log[base+50]); end
      end
      par = 1'b0; two = 1'b0;
   endtask

   task automatic test_overflow();
      int base, mm, pulses, early;
      @(posedge clk); #1;
      div = 16'd4; par = 1'b0; two = 1'b0;
      exp_q.delete();
      add_idle(2);
      for (int i = 0; i < 17; i++) add_frame(DW'(i), 4, 0, 0, 0);
      add_idle(4);
      base = ncnt + 1;
      for (int i = 0; i < 18; i++) begin
         write = 1'b1; data = DW'(i);
         @(posedge clk); #1;
      end
      write = 1'b0;
      wait_cycles(700);
      checks++; if (full_log[base+15] !== 1'b0) begin errors++; $display("FAIL ovf_full_early got %b want 0", full_log[base+15]); end
      checks++; if (full_log[base+16] !== 1'b1) begin errors++; $display("FAIL ovf_full_at_17 got %b want 1", full_log[base+16]); end
      checks++; if (cnt_log[base+16] !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", cnt_log[base+16]); end
      pulses = 0; early = 0;
      for (int i = 0; i <= 40; i++) pulses += ovf_log[base+i];
      for (int i = 0; i <= 15; i++) early += ovf_log[base+i];
      checks++; if (pulses != 1) begin errors++; $display("FAIL ovf_pulses got %0d want 1", pulses); end
      checks++; if (early != 0) begin errors++; $display("FAIL ovf_too_early got %0d want 0", early); end
      mm = first_mismatch(base);
      checks++; if (mm != -1) begin errors++; $display("FAIL ovf_wave sample %0d got %b want %b", mm, ser_log[base+mm], exp_q[mm]); end
      checks++; if (busy_log[base+2+680+2] !== 1'b0) begin errors++; $display("FAIL ovf_busy_end got %b want 0", busy_log[base+684]); end
   endtask

   task automatic test_divider_change();
      int base, mm;
      @(posedge clk); #1;
      div = 16'd4; par = 1'b0; two = 1'b0;
      exp_q.delete();
      add_idle(2); add_frame(8'hC3, 4, 0, 0, 0); add_frame(8'h5A, 8, 0, 0, 0); add_idle(4);
      base = ncnt + 1;
      push(8'hC3);
      push(8'h5A);
      repeat (8) @(posedge clk);
      #1 div = 16'd8;
      wait_cycles(2 + 40 + 80 + 6);
      mm = first_mismatch(base);
      checks++; if (mm != -1) begin errors++; $display("FAIL divchg_wave sample %0d got %b want %b", mm, ser_log[base+mm], exp_q[mm]); end
      div = 16'd4;
   endtask

   task automatic test_random();
      int          base, mm, n, dv;
      bit          p, ev, ts;
      logic [DW-1:0] bytes[$];
      for (int it = 0; it < 4; it++) begin
         @(posedge clk); #1;
         dv = $urandom_range(0, 6);
         p  = 1'($urandom_range(0, 1));
         ev = 1'($urandom_range(0, 1));
         ts = 1'($urandom_range(0, 1));
         n  = $urandom_range(1, 5);
         div = DIVW'(dv); par = p; even = ev; two = ts;
         bytes.delete();
         for (int i = 0; i < n; i++) bytes.push_back(DW'($urandom));
         exp_q.delete();
         add_idle(2);
         foreach (bytes[i]) add_frame(bytes[i], dv, p, ev, ts);
         add_idle(4);
         base = ncnt + 1;
         foreach (bytes[i]) push(bytes[i]);
         wait_cycles(exp_q.size() + 4);
         mm = first_mismatch(base);
         checks++; if (mm != -1) begin
            errors++; $display("FAIL random_wave it=%0d div=%0d par=%0d even=%0d two=%0d sample %0d got %b want %b",
                               it, dv, p, ev, ts, mm, ser_log[base+mm], exp_q[mm]);
         end
         checks++; if (busy_log[base+exp_q.size()-1] !== 1'b0 || cnt_log[base+exp_q.size()-1] !== 5'd0) begin
            errors++; $display("FAIL random_drain it=%0d busy=%b count=%0d want 0/0", it,
                               busy_log[base+exp_q.size()-1], cnt_log[base+exp_q.size()-1]);
         end
      end
      div = 16'd4; par = 1'b0; two = 1'b0; even = 1'b0;
   endtask

   task automatic test_reset_midframe();
      int rb, lows, busies;
      @(posedge clk); #1;
      div = 16'd4;
      push(8'h00);
      push(8'hA5);
      push(8'h3C);
      repeat (10) @(posedge clk);
      #1;
      rb  = ncnt + 1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      wait_cycles(150);
      checks++; if (ser_log[rb] !== 1'b1) begin errors++; $display("FAIL midreset_serial got %b want 1", ser_log[rb]); end
      checks++; if (cnt_log[rb] !== 5'd0) begin errors++; $display("FAIL midreset_count got %0d want 0", cnt_log[rb]); end
      checks++; if (busy_log[rb] !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy_log[rb]); end
      lows = 0; busies = 0;
      for (int i = 0; i < 150; i++) begin
         lows   += (ser_log[rb+i] !== 1'b1);
         busies += (busy_log[rb+i] !== 1'b0);
      end
      checks++; if (lows != 0 || busies != 0) begin
         errors++; $display("FAIL midreset_quiet got low_samples=%0d busy_samples=%0d want 0/0", lows, busies);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_overflow();
      test_divider_change();
      test_random();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
